// File: rtl/multiplier_64_bit_sequential_pkg.sv
// Shared definitions for the sequential 64x64 shift-add multiplier.
// Contents: op encodings, FSM state encoding, XZR register number and the
// number of CALC steps per operation.
package multiplier_64_bit_sequential_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_SMULH = 2'b10;  // 2'b11 is reserved and runs as MUL

   localparam logic [4:0] XZR_ADDRESS = 5'd31;
   localparam int         STEP_COUNT  = 64;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CALC  = 2'b01,
      S_FIX   = 2'b10,
      S_WRITE = 2'b11
   } state_e;

endpackage

// File: rtl/multiply_shift_add_datapath.sv
// Radix-2 shift-add datapath: 2N-bit accumulator, multiplicand and multiplier
// registers, and the add/shift/negate logic.
// Ports:
//   clock, reset     rising-edge clock, async active-low reset
//   load_i           capture operands (magnitudes when signed_i), clear accumulator
//   step_i           one shift-add step
//   fix_i            apply sign correction to the accumulator
//   signed_i         operands are two's complement (SMULH)
//   operand_a/b_i    multiplicand / multiplier
//   product_o        sign-corrected product (valid as the FIX-cycle value)
module multiply_shift_add_datapath #(
   parameter int N = 64
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load_i,
   input  logic           step_i,
   input  logic           fix_i,
   input  logic           signed_i,
   input  logic [N-1:0]   operand_a_i,
   input  logic [N-1:0]   operand_b_i,
   output logic [2*N-1:0] product_o
);

   logic [2*N-1:0] acc_q;
   logic [N-1:0]   mcand_q, mplier_q;
   logic           sign_q;

   logic [N-1:0]   abs_a, abs_b;
   logic [N:0]     sum;
   logic [2*N-1:0] fixed;

   // |-2^(N-1)| = 2^(N-1) still fits in N unsigned bits.
   assign abs_a = (signed_i && operand_a_i[N-1]) ? -operand_a_i : operand_a_i;
   assign abs_b = (signed_i && operand_b_i[N-1]) ? -operand_b_i : operand_b_i;

   // Carry out of the upper-half add is kept as bit N and shifted back in.
   assign sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
   assign fixed = sign_q ? -acc_q : acc_q;
   assign product_o = fixed;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
      end else if (load_i) begin
         acc_q    <= '0;
         mcand_q  <= abs_a;
         mplier_q <= abs_b;
         sign_q   <= signed_i & (operand_a_i[N-1] ^ operand_b_i[N-1]);
      end else if (step_i) begin
         acc_q    <= {sum, acc_q[N-1:1]};
         mplier_q <= {1'b0, mplier_q[N-1:1]};
      end else if (fix_i) begin
         acc_q    <= fixed;
      end
   end

endmodule

// File: rtl/multiplier_64_bit_sequential.sv
// Iterative 64x64 multiplier (MUL / UMULH / SMULH) feeding the register file
// write port. FSM IDLE -> CALC (64 steps) -> FIX -> WRITE -> IDLE.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   start, op, dest       request (sampled only in IDLE), operation, dest reg
//   operand_a, operand_b  register file out_a / out_b
//   busy, done            state != IDLE, one-cycle completion pulse
//   result                selected product half, held until next completion
//   write, address        register file write strobe and address
module multiplier_64_bit_sequential
   import multiplier_64_bit_sequential_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] operand_a,
   input  logic [N-1:0] operand_b,
   input  logic [4:0]   dest,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         write,
   output logic [4:0]   address
);

   localparam int CW = $clog2(STEP_COUNT);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     op_q;
   logic [4:0]     dest_q;
   logic [N-1:0]   result_q;
   logic [4:0]     address_q;
   logic           done_q, write_q, busy_q;
   logic           load, step, fix;
   logic [2*N-1:0] product;

   multiply_shift_add_datapath #(.N(N)) u_dp (
      .clock       (clock),
      .reset       (reset),
      .load_i      (load),
      .step_i      (step),
      .fix_i       (fix),
      .signed_i    (op == OP_SMULH),
      .operand_a_i (operand_a),
      .operand_b_i (operand_b),
      .product_o   (product)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = S_CALC;
         end
         S_CALC: begin
            step  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(STEP_COUNT - 1)) state_d = S_FIX;
         end
         S_FIX:   begin
            fix     = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch and registered outputs. write and address update on the
   // same edge so the register file never sees a torn write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q      <= OP_MUL;
         dest_q    <= '0;
         result_q  <= '0;
         address_q <= '0;
         done_q    <= 1'b0;
         write_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (load) begin
            op_q   <= op;
            dest_q <= dest;
            busy_q <= 1'b1;
         end
         if (fix) begin
            result_q  <= (op_q == OP_UMULH || op_q == OP_SMULH) ? product[2*N-1:N]
                                                                : product[N-1:0];
            address_q <= dest_q;
            done_q    <= 1'b1;
            write_q   <= (dest_q != XZR_ADDRESS);
         end
         if (state_q == S_WRITE) begin
            done_q  <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign write   = write_q;
   assign address = address_q;

endmodule

// File: tb/tb_multiplier_64_bit_sequential.sv
// Directed bench for multiplier_64_bit_sequential with a result scoreboard.
module tb_multiplier_64_bit_sequential;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [63:0] operand_a = '0, operand_b = '0;
   logic [4:0]  dest = '0;
   logic        busy, done, write;
   logic [63:0] result;
   logic [4:0]  address;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  addr;
      logic        wr;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   multiplier_64_bit_sequential dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .dest(dest),
      .busy(busy), .done(done), .result(result), .write(write), .address(address)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      if (o == 2'b10) p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      else            p = {64'd0, a} * {64'd0, b};
      return (o == 2'b01 || o == 2'b10) ? p[127:64] : p[63:0];
   endfunction

   task automatic no_activity(input string tag, input int cycles);
      logic bad = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock); #1;
         if (done || write) bad = 1'b1;
      end
      chk(tag, {63'd0, bad}, 64'd0);
   endtask

   // mode 0: plain; 1: second start at cycle 10 and operand_a flip mid-CALC;
   // 2: reset pulse at CALC step 30, operation is discarded.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d,
                        input logic [63:0] exp, input int mode);
      int   n;
      logic got;
      exp_t e;
      @(negedge clock);
      start = 1'b1; op = o; operand_a = a; operand_b = b; dest = d;
      if (mode != 2) sb.push_back('{exp, d, (d != 5'd31)});
      @(posedge clock); #1;
      start = 1'b0;
      chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
      n = 0; got = 1'b0;
      while (n < 200 && !got) begin
         @(posedge clock); n++; #1;
         if (mode == 1 && n == 10) begin
            start = 1'b1; op = 2'b00; operand_a = 64'd9; operand_b = 64'd9; dest = 5'd4;
         end
         if (mode == 1 && n == 11) start = 1'b0;
         if (mode == 1 && n == 30) operand_a = ~operand_a;
         if (mode == 2 && n == 30) begin
            reset = 1'b0; #1;
            chk({tag, "_rst_busy"},    {63'd0, busy},  64'd0);
            chk({tag, "_rst_done"},    {63'd0, done},  64'd0);
            chk({tag, "_rst_write"},   {63'd0, write}, 64'd0);
            chk({tag, "_rst_result"},  result,         64'd0);
            chk({tag, "_rst_address"}, {59'd0, address}, 64'd0);
            @(negedge clock); reset = 1'b1;
            no_activity({tag, "_no_write_after_reset"}, 80);
            return;
         end
         if (done) got = 1'b1;
      end
      chk({tag, "_latency"}, 64'(n), 64'd65);
      if (got) begin
         if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
         else begin
            e = sb.pop_front();
            chk({tag, "_result"},  result,            e.res);
            chk({tag, "_address"}, {59'd0, address},  {59'd0, e.addr});
            chk({tag, "_write"},   {63'd0, write},    {63'd0, e.wr});
         end
         @(posedge clock); #1;
         chk({tag, "_done_fall"},  {63'd0, done},  64'd0);
         chk({tag, "_write_fall"}, {63'd0, write}, 64'd0);
         chk({tag, "_busy_fall"},  {63'd0, busy},  64'd0);
      end
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [1:0]  ro;
      #12;
      chk("reset_busy",    {63'd0, busy},    64'd0);
      chk("reset_done",    {63'd0, done},    64'd0);
      chk("reset_write",   {63'd0, write},   64'd0);
      chk("reset_result",  result,           64'd0);
      chk("reset_address", {59'd0, address}, 64'd0);
      @(negedge clock); reset = 1'b1;

      do_op("mul_3x5",     2'b00, 64'd3, 64'd5, 5'd2, 64'd15, 0);
      do_op("umulh_ff",    2'b01, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_op("mul_ff",      2'b00, '1, '1, 5'd7, 64'h0000_0000_0000_0001, 0);
      do_op("smulh_ff",    2'b10, '1, '1, 5'd8, 64'h0000_0000_0000_0000, 0);
      do_op("smulh_m1x1",  2'b10, '1, 64'd1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      do_op("smulh_min",   2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            5'd10, 64'h4000_0000_0000_0000, 0);
      do_op("reserved_op", 2'b11, 64'd1234567, 64'd7654321, 5'd11, 64'd9449772114007, 0);
      do_op("mul_xzr",     2'b00, 64'd7, 64'd6, 5'd31, 64'd42, 1);
      no_activity("dropped_start", 80);
      do_op("reset_mid",   2'b00, 64'd12, 64'd12, 5'd5, 64'd144, 2);
      do_op("mul_2x2",     2'b00, 64'd2, 64'd2, 5'd6, 64'd4, 0);

      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         ro = 2'(i % 3);
         do_op($sformatf("rand%0d", i), ro, ra, rb, 5'(12 + i), model(ro, ra, rb), 0);
      end

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
